// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } tx_state_t;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: free-runs 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_cnt
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == CNT_MAX);

    // Held at zero while cleared so the first bit after a clear is full length.
    always_comb begin
        cnt_d = cnt_q;
        if (clr || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a FIFO one word at a time and serialises each word as a UART frame
// (start, LSB-first data, optional parity, stop).
module fifo_uart_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned BITS         = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [BITS-1:0] fifo_dout,
    input  logic            fifo_pndng,
    output logic            fifo_pop,
    input  logic            enable,
    output logic            tx,
    output logic            busy
);

    localparam int unsigned BCNT_W = $clog2(BITS + 1);
    localparam logic [BCNT_W-1:0] LAST_DATA = BCNT_W'(BITS - 1);
    localparam logic [BCNT_W-1:0] LAST_STOP = BCNT_W'(STOP_BITS - 1);

    tx_state_t         state_q,   state_d;
    logic [BITS-1:0]   shift_q,   shift_d;
    logic [BITS-1:0]   word_q,    word_d;
    logic [BCNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic              tx_q,      tx_d;
    logic              busy_q,    busy_d;
    logic              pop_q,     pop_d;

    logic tick;
    logic baud_clr_c;
    logic par_bit_c;

    assign baud_clr_c = (state_q == IDLE);
    assign par_bit_c  = (PARITY == PAR_ODD) ? ~^word_q : ^word_q;

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk (clk),
        .rst (rst),
        .clr (baud_clr_c),
        .tick(tick)
    );

    // Next-state and registered-output logic; every non-IDLE state advances only on tick.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        word_d    = word_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        pop_d     = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (enable && fifo_pndng) begin
                    state_d   = START;
                    shift_d   = fifo_dout;
                    word_d    = fifo_dout;
                    pop_d     = 1'b1;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                    bit_cnt_d = '0;
                end
            end
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        if (PARITY != PAR_NONE) begin
                            state_d = PAR;
                            tx_d    = par_bit_c;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCNT_W'(1);
                        tx_d      = shift_d[0];
                    end
                end
            end
            PAR: begin
                if (tick) begin
                    state_d   = STOP;
                    tx_d      = 1'b1;
                    bit_cnt_d = '0;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (tick) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        state_d   = IDLE;
                        busy_d    = 1'b0;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCNT_W'(1);
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                tx_d      = 1'b1;
                busy_d    = 1'b0;
                bit_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            word_q    <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            pop_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            word_q    <= word_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            pop_q     <= pop_d;
        end
    end

    assign fifo_pop = pop_q;
    assign tx       = tx_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench: three transmitter configurations fed from modelled FIFOs,
// frames decoded mid-bit from tx and compared against the pushed words.
module tb_fifo_uart_tx;

    localparam int unsigned N = 4;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;

    logic [2:0] tx_w;
    logic [2:0] busy_w;
    logic [2:0] pop_w;
    logic [2:0] pndng_w;
    logic [7:0] dout_w [3];

    logic [7:0] fmem [3][DEPTH];
    int         ftail [3];
    logic [7:0] exp_q [3][$];

    int pushed   = 0;
    int checks   = 0;
    int failures = 0;
    bit done_req = 1'b0;

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_par(input logic [7:0] w, input int unsigned mode);
        int ones;
        ones = $countones(w);
        if (mode == 1) return (ones % 2) == 1;
        return (ones % 2) == 0;
    endfunction

    task automatic push(input logic [7:0] v);
        for (int g = 0; g < 3; g++) begin
            fmem[g][ftail[g] % DEPTH] = v;
            ftail[g] = ftail[g] + 1;
            exp_q[g].push_back(v);
        end
        pushed++;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((pndng_w != 3'b000 || busy_w != 3'b000) && n < budget);
        chk(pndng_w == 3'b000 && busy_w == 3'b000, "drain_timeout", n, budget);
        repeat (4) @(negedge clk);
    endtask

    task automatic quiet(input int cycles, input string name);
        repeat (cycles) begin
            @(negedge clk);
            chk(tx_w == 3'b111 && busy_w == 3'b000 && pop_w == 3'b000, name,
                int'({tx_w, busy_w, pop_w}), int'(9'b111_000_000));
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int unsigned PAR = (g == 0) ? 0 : ((g == 1) ? 1 : 2);
        localparam int unsigned STP = (g == 1) ? 2 : 1;

        int fhead;
        int pop_cnt;
        bit prev_pop;
        bit aborted;

        fifo_uart_tx #(
            .BITS        (8),
            .CLKS_PER_BIT(N),
            .PARITY      (PAR),
            .STOP_BITS   (STP)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .fifo_dout (dout_w[g]),
            .fifo_pndng(pndng_w[g]),
            .fifo_pop  (pop_w[g]),
            .enable    (en),
            .tx        (tx_w[g]),
            .busy      (busy_w[g])
        );

        assign pndng_w[g] = (fhead != ftail[g]);
        assign dout_w[g]  = fmem[g][fhead % DEPTH];

        always @(posedge clk) begin
            if (pop_w[g] && pndng_w[g]) fhead <= fhead + 1;
        end

        always @(negedge clk) begin
            if (pop_w[g]) begin
                pop_cnt = pop_cnt + 1;
                chk(!prev_pop, "double_pop", 1, 0);
            end
            prev_pop = pop_w[g];
        end

        task automatic wait_n(input int k);
            repeat (k) begin
                @(negedge clk);
                if (rst) aborted = 1'b1;
            end
        endtask

        initial begin : mon
            logic [7:0] w;
            logic [7:0] got;
            bit         pend;
            bit         exp_start;
            pend = 1'b0;
            forever begin
                if (!pend) @(negedge clk);
                pend = 1'b0;
                if (!rst && tx_w[g] === 1'b0) begin
                    aborted = 1'b0;
                    chk(exp_q[g].size() != 0, "frame_expected", exp_q[g].size(), 1);
                    w = (exp_q[g].size() != 0) ? exp_q[g].pop_front() : 8'h00;
                    chk(pop_w[g] === 1'b1, "pop_at_start", int'(pop_w[g]), 1);
                    chk(busy_w[g] === 1'b1, "busy_at_start", int'(busy_w[g]), 1);
                    wait_n(2);
                    if (!aborted) chk(tx_w[g] === 1'b0, "start_bit", int'(tx_w[g]), 0);
                    for (int i = 0; i < 8; i++) begin
                        wait_n(N);
                        got[i] = tx_w[g];
                    end
                    if (!aborted) chk(got === w, "data_word", int'(got), int'(w));
                    if (PAR != 0) begin
                        wait_n(N);
                        if (!aborted)
                            chk(tx_w[g] === exp_par(w, PAR), "parity_bit",
                                int'(tx_w[g]), int'(exp_par(w, PAR)));
                    end
                    for (int s = 0; s < int'(STP); s++) begin
                        wait_n(N);
                        if (!aborted) chk(tx_w[g] === 1'b1, "stop_bit", int'(tx_w[g]), 1);
                    end
                    wait_n(1);
                    if (!aborted) chk(busy_w[g] === 1'b1, "busy_last_cycle", int'(busy_w[g]), 1);
                    wait_n(1);
                    if (!aborted) begin
                        chk(busy_w[g] === 1'b0 && tx_w[g] === 1'b1, "idle_after_frame",
                            int'({busy_w[g], tx_w[g]}), 1);
                        exp_start = en && pndng_w[g];
                        wait_n(1);
                        if (!aborted && exp_start) begin
                            chk(tx_w[g] === 1'b0, "b2b_start", int'(tx_w[g]), 0);
                            pend = (tx_w[g] === 1'b0) && !rst;
                        end
                    end
                end
            end
        end

        initial begin : endchk
            wait (done_req);
            chk(exp_q[g].size() == 0, "frames_outstanding", exp_q[g].size(), 0);
            chk(pop_cnt == pushed, "pop_count", pop_cnt, pushed);
        end
    end

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(tx_w == 3'b111 && busy_w == 3'b000 && pop_w == 3'b000, "reset_state",
            int'({tx_w, busy_w, pop_w}), int'(9'b111_000_000));
        @(posedge clk);
        #1 rst = 1'b0;

        // Reset lands in the stop bit of the 40-cycle frame.
        en = 1'b1;
        push(8'hA5);
        @(posedge clk);
        repeat (37) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk(tx_w == 3'b111 && busy_w == 3'b000 && pop_w == 3'b000, "reset_mid_frame",
            int'({tx_w, busy_w, pop_w}), int'(9'b111_000_000));
        @(posedge clk);
        #1 rst = 1'b0;
        quiet(100, "quiet_after_reset");

        // Single word, then three back-to-back, then the parity word.
        @(posedge clk);
        #1 push(8'hA5);
        drain(200);
        @(posedge clk);
        #1;
        push(8'h00);
        push(8'hFF);
        push(8'h3C);
        drain(600);
        @(posedge clk);
        #1 push(8'h07);
        drain(300);

        // Enable dropped mid-DATA: frame completes, second word stays queued.
        @(posedge clk);
        #1;
        push(8'h5A);
        push(8'hC3);
        @(posedge clk);
        repeat (12) @(posedge clk);
        #1 en = 1'b0;
        repeat (70) @(negedge clk);
        chk(pndng_w == 3'b111 && busy_w == 3'b000, "enable_low_hold",
            int'({pndng_w, busy_w}), int'(6'b111_000));
        @(posedge clk);
        #1 en = 1'b1;
        drain(300);

        quiet(50, "quiet_no_data");

        for (int k = 0; k < 24; k++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 2) != 0) push(8'($urandom_range(0, 255)));
            en = ($urandom_range(0, 4) != 0);
            repeat ($urandom_range(1, 40)) @(posedge clk);
        end
        @(posedge clk);
        #1 en = 1'b1;
        drain(3000);

        done_req = 1'b1;
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
